alu_exec_unit: RTL

Parametrised, handshaked ALU execution unit for the RISC datapath. It merges the ALU-control decode (`alu_op` + `opcode` → 3-bit operation) with a registered datapath of configurable width. It adds valid/ready flow control, a one-bit-per-cycle iterative shifter, result flags and illegal-operation detection. It sits between the decode/issue stage and writeback/branch resolution.

---
 rtl/alu_exec_unit.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: handshaked ALU execution unit.
// Decodes {alu_op, opcode} into a 3-bit operation and registers the result.
// Logical shifts move one bit position per cycle.
// Flags and the error bit are registered alongside the result, so no input
// reaches any out_* port combinationally.
module alu_exec_unit #(
    parameter int DATA_W  = 16,
    parameter int SHAMT_W = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        alu_op,
    input  logic [3:0]        opcode,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [2:0]        out_alu_cnt,
    output logic              out_zero,
    output logic              out_carry,
    output logic              out_ovf,
    output logic              out_err
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_INV = 3'd2;
    localparam logic [2:0] OP_LSL = 3'd3;
    localparam logic [2:0] OP_LSR = 3'd4;
    localparam logic [2:0] OP_AND = 3'd5;
    localparam logic [2:0] OP_OR  = 3'd6;
    localparam logic [2:0] OP_SLT = 3'd7;

    state_t              state_q;
    logic [DATA_W-1:0]   acc_q;
    logic [SHAMT_W-1:0]  cnt_q;
    logic                dir_q;   // 1 = shift left

    logic [2:0]          dec_cnt;
    logic                dec_err;
    logic [SHAMT_W-1:0]  shamt;
    logic                is_shift;
    logic [DATA_W:0]     sum;
    logic [DATA_W:0]     dif;
    logic [DATA_W-1:0]   res;
    logic                res_carry;
    logic                res_ovf;
    logic [DATA_W-1:0]   shift_next;
    logic                shift_out;

    assign in_ready = (state_q == IDLE);
    assign shamt    = in_b[SHAMT_W-1:0];

    // Decode the operation class and data-op selector into alu_cnt / err.
    always_comb begin
        dec_cnt = OP_ADD;
        dec_err = 1'b0;
        unique case (alu_op)
            2'b10: dec_cnt = OP_ADD;
            2'b01: dec_cnt = OP_SUB;
            2'b00: begin
                case (opcode)
                    4'd2:    dec_cnt = OP_ADD;
                    4'd3:    dec_cnt = OP_SUB;
                    4'd4:    dec_cnt = OP_INV;
                    4'd5:    dec_cnt = OP_LSL;
                    4'd6:    dec_cnt = OP_LSR;
                    4'd7:    dec_cnt = OP_AND;
                    4'd8:    dec_cnt = OP_OR;
                    4'd9:    dec_cnt = OP_SLT;
                    default: dec_err = 1'b1;
                endcase
            end
            2'b11: dec_err = 1'b1;
        endcase
    end

    // Single-cycle result and flags for everything except multi-step shifts.
    always_comb begin
        sum       = {1'b0, in_a} + {1'b0, in_b};
        // SUB as a + ~b + 1; the carry out is the no-borrow flag.
        dif       = {1'b0, in_a} + {1'b0, ~in_b} + {{DATA_W{1'b0}}, 1'b1};
        res       = '0;
        res_carry = 1'b0;
        res_ovf   = 1'b0;
        is_shift  = !dec_err && (dec_cnt == OP_LSL || dec_cnt == OP_LSR);
        if (!dec_err) begin
            unique case (dec_cnt)
                OP_ADD: begin
                    res       = sum[DATA_W-1:0];
                    res_carry = sum[DATA_W];
                    res_ovf   = (in_a[DATA_W-1] == in_b[DATA_W-1]) &&
                                (sum[DATA_W-1] != in_a[DATA_W-1]);
                end
                OP_SUB: begin
                    res       = dif[DATA_W-1:0];
                    res_carry = dif[DATA_W];
                    res_ovf   = (in_a[DATA_W-1] != in_b[DATA_W-1]) &&
                                (dif[DATA_W-1] != in_a[DATA_W-1]);
                end
                OP_INV: res = ~in_a;
                // Only reached here with a zero shift amount.
                OP_LSL, OP_LSR: res = in_a;
                OP_AND: res = in_a & in_b;
                OP_OR:  res = in_a | in_b;
                OP_SLT: res = {{(DATA_W-1){1'b0}}, $signed(in_a) < $signed(in_b)};
            endcase
        end
    end

    // One-bit shift step of the accumulator and the bit it pushes out.
    always_comb begin
        shift_next = dir_q ? {acc_q[DATA_W-2:0], 1'b0} : {1'b0, acc_q[DATA_W-1:1]};
        shift_out  = dir_q ? acc_q[DATA_W-1] : acc_q[0];
    end

    // Control FSM with registered result and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            dir_q       <= 1'b0;
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_alu_cnt <= '0;
            out_zero    <= 1'b0;
            out_carry   <= 1'b0;
            out_ovf     <= 1'b0;
            out_err     <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        out_alu_cnt <= dec_cnt;
                        out_err     <= dec_err;
                        if (is_shift && shamt != '0) begin
                            acc_q   <= in_a;
                            cnt_q   <= shamt;
                            dir_q   <= (dec_cnt == OP_LSL);
                            out_ovf <= 1'b0;
                            state_q <= SHIFT;
                        end else begin
                            out_result <= res;
                            out_zero   <= (res == '0);
                            out_carry  <= res_carry;
                            out_ovf    <= res_ovf;
                            out_valid  <= 1'b1;
                            state_q    <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    acc_q <= shift_next;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == {{(SHAMT_W-1){1'b0}}, 1'b1}) begin
                        out_result <= shift_next;
                        out_zero   <= (shift_next == '0);
                        out_carry  <= shift_out;
                        out_valid  <= 1'b1;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
